dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: m0 = core load/store path,
//  m1 = debug/loader port (program load, memory inspection while the core is stalled).

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 26 ++
 rtl/dmem_arbiter_pick.sv | 39 +++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: owner encoding and the
// conversion from a one-hot grant vector to an owner value.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  function automatic owner_t gntToOwner(input logic [1:0] gnt);
    owner_t result;
    case (gnt)
      2'b01:   result = OWN_M0;
      2'b10:   result = OWN_M1;
      default: result = OWN_NONE;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter. The master modport is the
// requester (core or debug port); the slave modport is the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter_pick.sv
// Pure combinational grant decision: single requester always wins, ties are
// broken by burst ownership and, from idle, by whoever was served last.
module dmem_arbiter_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic [1:0]       i_req,
  input  owner_t           i_owner,
  input  logic [CNT_W-1:0] i_burstCnt,
  input  owner_t           i_last,
  output logic [1:0]       o_gnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic w_burstOpen;

  assign w_burstOpen = (i_burstCnt < MAX_CNT);

  // The current owner keeps the memory until its burst budget is spent.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: begin
        case (i_owner)
          OWN_M0:  o_gnt = w_burstOpen ? 2'b01 : 2'b10;
          OWN_M1:  o_gnt = w_burstOpen ? 2'b10 : 2'b01;
          default: o_gnt = (i_last == OWN_M0) ? 2'b10 : 2'b01;
        endcase
      end
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (m0) and the
// debug/loader port (m1): one access per cycle, read data one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0_if,
  dmem_arbiter_if.slave     m1_if,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wd,
  input  logic [DATA_W-1:0] i_mem_rd
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  owner_t            r_owner;
  owner_t            r_last;
  logic [CNT_W-1:0]  r_burstCnt;
  logic              r_m0Rvalid;
  logic              r_m1Rvalid;
  logic [DATA_W-1:0] r_m0Rdata;
  logic [DATA_W-1:0] r_m1Rdata;

  logic [1:0]        w_pick;
  logic [1:0]        w_gnt;
  owner_t            w_gntOwner;

  dmem_arbiter_pick #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .i_req      ({m1_if.req, m0_if.req}),
    .i_owner    (r_owner),
    .i_burstCnt (r_burstCnt),
    .i_last     (r_last),
    .o_gnt      (w_pick)
  );

  // No access may reach memory while reset is held.
  assign w_gnt      = rst ? 2'b00 : w_pick;
  assign w_gntOwner = gntToOwner(w_gnt);

  assign m0_if.gnt    = w_gnt[0];
  assign m1_if.gnt    = w_gnt[1];
  assign m0_if.rvalid = r_m0Rvalid;
  assign m1_if.rvalid = r_m1Rvalid;
  assign m0_if.rdata  = r_m0Rdata;
  assign m1_if.rdata  = r_m1Rdata;

  always_comb begin
    o_mem_we   = 1'b0;
    o_mem_addr = '0;
    o_mem_wd   = '0;
    if (w_gnt[0]) begin
      o_mem_we   = m0_if.we;
      o_mem_addr = m0_if.addr;
      o_mem_wd   = m0_if.wdata;
    end else if (w_gnt[1]) begin
      o_mem_we   = m1_if.we;
      o_mem_addr = m1_if.addr;
      o_mem_wd   = m1_if.wdata;
    end
  end

  // Ownership FSM, burst counter and the one-cycle read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWN_NONE;
      r_last     <= OWN_M1;
      r_burstCnt <= '0;
      r_m0Rvalid <= 1'b0;
      r_m1Rvalid <= 1'b0;
      r_m0Rdata  <= '0;
      r_m1Rdata  <= '0;
    end else begin
      r_owner <= w_gntOwner;
      if (w_gnt == 2'b00) begin
        r_burstCnt <= '0;
      end else if (w_gntOwner == r_owner) begin
        r_burstCnt <= (r_burstCnt == MAX_CNT) ? MAX_CNT : r_burstCnt + 1'b1;
      end else begin
        r_burstCnt <= CNT_W'(1);
      end
      if (w_gnt != 2'b00) begin
        r_last <= w_gntOwner;
      end
      r_m0Rvalid <= w_gnt[0] & ~m0_if.we;
      r_m1Rvalid <= w_gnt[1] & ~m1_if.we;
      if (w_gnt[0] && !m0_if.we) begin
        r_m0Rdata <= i_mem_rd;
      end
      if (w_gnt[1] && !m1_if.we) begin
        r_m1Rdata <= i_mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by a long
// randomized run, all compared against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWd;
  logic [31:0] memRd;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0Bus ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1Bus ();

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_if      (m0Bus),
    .m1_if      (m1Bus),
    .o_mem_we   (memWe),
    .o_mem_addr (memAddr),
    .o_mem_wd   (memWd),
    .i_mem_rd   (memRd)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT: combinational read, write on the edge.
  logic [31:0] physMem [16] = '{default: '0};
  assign memRd = physMem[memAddr[5:2]];
  always @(posedge clk) begin
    if (memWe) physMem[memAddr[5:2]] <= memWd;
  end

  int checks = 0;
  int passed = 0;

  // Reference model state: who was served in the previous cycle and for how long.
  int          modelPrev   = -1;
  int          modelStreak = 0;
  int          modelLast   = 1;
  logic        expRvalid [2] = '{1'b0, 1'b0};
  logic [31:0] expRdata  [2] = '{32'd0, 32'd0};
  logic [31:0] refMem    [16] = '{default: '0};
  logic [1:0]  lastGnt = 2'b00;
  int          wait0 = 0;
  int          wait1 = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic logic [1:0] modelGrant(input logic r0, input logic r1);
    if (r0 && !r1) return 2'b01;
    if (r1 && !r0) return 2'b10;
    if (!r0 && !r1) return 2'b00;
    if (modelPrev < 0) return (modelLast == 0) ? 2'b10 : 2'b01;
    if (modelStreak < MAX_BURST) return (modelPrev == 0) ? 2'b01 : 2'b10;
    return (modelPrev == 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic modelUpdate(input logic [1:0] expG);
    int granted;
    if (rst) begin
      modelPrev   = -1;
      modelStreak = 0;
      modelLast   = 1;
      expRvalid   = '{1'b0, 1'b0};
      expRdata    = '{32'd0, 32'd0};
      return;
    end
    expRvalid[0] = expG[0] && !m0Bus.we;
    expRvalid[1] = expG[1] && !m1Bus.we;
    if (expRvalid[0]) expRdata[0] = refMem[m0Bus.addr[5:2]];
    if (expRvalid[1]) expRdata[1] = refMem[m1Bus.addr[5:2]];
    if (expG[0] && m0Bus.we) refMem[m0Bus.addr[5:2]] = m0Bus.wdata;
    if (expG[1] && m1Bus.we) refMem[m1Bus.addr[5:2]] = m1Bus.wdata;
    if (expG == 2'b00) begin
      modelPrev   = -1;
      modelStreak = 0;
    end else begin
      granted = expG[1] ? 1 : 0;
      if (granted == modelPrev) modelStreak = (modelStreak < MAX_BURST) ? modelStreak + 1 : MAX_BURST;
      else modelStreak = 1;
      modelPrev = granted;
      modelLast = granted;
    end
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
  task automatic runCycle();
    logic [1:0]  expG;
    logic        expWe;
    logic [31:0] expAddr;
    logic [31:0] expWd;
    @(negedge clk);
    expG    = rst ? 2'b00 : modelGrant(m0Bus.req, m1Bus.req);
    expWe   = expG[0] ? m0Bus.we    : (expG[1] ? m1Bus.we    : 1'b0);
    expAddr = expG[0] ? m0Bus.addr  : (expG[1] ? m1Bus.addr  : 32'd0);
    expWd   = expG[0] ? m0Bus.wdata : (expG[1] ? m1Bus.wdata : 32'd0);
    checkOutput("m0Gnt", m0Bus.gnt, expG[0]);
    checkOutput("m1Gnt", m1Bus.gnt, expG[1]);
    checkOutput("bothGnt", m0Bus.gnt & m1Bus.gnt, 0);
    checkOutput("memWe", memWe, expWe);
    checkOutput("memAddr", memAddr, expAddr);
    checkOutput("memWd", memWd, expWd);
    checkOutput("m0Rvalid", m0Bus.rvalid, expRvalid[0]);
    checkOutput("m1Rvalid", m1Bus.rvalid, expRvalid[1]);
    checkOutput("m0Rdata", m0Bus.rdata, expRdata[0]);
    checkOutput("m1Rdata", m1Bus.rdata, expRdata[1]);
    lastGnt = {m1Bus.gnt, m0Bus.gnt};
    if (rst) begin
      wait0 = 0;
      wait1 = 0;
    end else begin
      if (m0Bus.req && !m0Bus.gnt) begin
        wait0++;
        checkOutput("m0Wait", wait0 <= MAX_BURST, 1);
      end else wait0 = 0;
      if (m1Bus.req && !m1Bus.gnt) begin
        wait1++;
        checkOutput("m1Wait", wait1 <= MAX_BURST, 1);
      end else wait1 = 0;
    end
    @(posedge clk);
    modelUpdate(expG);
    #1;
  endtask

  task automatic applyStimulus(output logic req, output logic we, output logic [31:0] addr, output logic [31:0] wdata);
    req   = ($urandom_range(0, 99) < 60);
    we    = $urandom_range(0, 1) == 1;
    addr  = 32'($urandom_range(0, 15)) << 2;
    wdata = $urandom;
  endtask

  logic [1:0] burstPat [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};

  initial begin
    m0Bus.req = 1'b1; m0Bus.we = 1'b0; m0Bus.addr = 32'h0; m0Bus.wdata = 32'h0;
    m1Bus.req = 1'b1; m1Bus.we = 1'b0; m1Bus.addr = 32'h4; m1Bus.wdata = 32'h0;

    // Reset held two cycles with both masters requesting.
    repeat (2) begin
      runCycle();
      checkOutput("rstGnt", lastGnt, 2'b00);
    end
    checkOutput("rstRvalid", {m1Bus.rvalid, m0Bus.rvalid}, 2'b00);
    checkOutput("rstRdata", m0Bus.rdata, 32'd0);
    rst = 1'b0;
    m0Bus.req = 1'b0; m1Bus.req = 1'b0;
    runCycle();

    // Single master write then read of the same word.
    m0Bus.req = 1'b1; m0Bus.we = 1'b1; m0Bus.addr = 32'h10; m0Bus.wdata = 32'hDEADBEEF;
    runCycle();
    checkOutput("wrGnt", lastGnt, 2'b01);
    m0Bus.we = 1'b0;
    runCycle();
    checkOutput("rdGnt", lastGnt, 2'b01);
    checkOutput("rdValid", m0Bus.rvalid, 1);
    checkOutput("rdData", m0Bus.rdata, 32'hDEADBEEF);
    checkOutput("m1Idle", m1Bus.rvalid, 0);
    m0Bus.req = 1'b0;
    runCycle();
    checkOutput("rdValidOnce", m0Bus.rvalid, 0);
    checkOutput("rdDataHold", m0Bus.rdata, 32'hDEADBEEF);

    // Tie from idle straight after reset: m0 first, then m1.
    rst = 1'b1;
    runCycle();
    rst = 1'b0;
    m0Bus.req = 1'b1; m0Bus.we = 1'b0; m0Bus.addr = 32'h10;
    m1Bus.req = 1'b1; m1Bus.we = 1'b0; m1Bus.addr = 32'h10;
    runCycle();
    checkOutput("tieFirst", lastGnt, 2'b01);
    m0Bus.req = 1'b0;
    runCycle();
    checkOutput("tieSecond", lastGnt, 2'b10);
    checkOutput("tieRdata", m1Bus.rdata, 32'hDEADBEEF);
    m1Bus.req = 1'b0;
    runCycle();

    // Continuous contention from idle with m1 served last.
    m0Bus.req = 1'b1; m0Bus.addr = 32'h0;
    m1Bus.req = 1'b1; m1Bus.addr = 32'h4;
    for (int i = 0; i < 10; i++) begin
      runCycle();
      checkOutput($sformatf("burst%0d", i), lastGnt, burstPat[i]);
    end

    // Reset arriving while m1 keeps reading.
    m0Bus.req = 1'b0;
    runCycle();
    checkOutput("preRstGnt", lastGnt, 2'b10);
    checkOutput("preRstRvalid", m1Bus.rvalid, 1);
    rst = 1'b1;
    runCycle();
    checkOutput("midRstGnt", lastGnt, 2'b00);
    checkOutput("midRstRvalid", m1Bus.rvalid, 0);
    rst = 1'b0;
    m1Bus.req = 1'b0;
    runCycle();

    // Randomized traffic; a pending request keeps its payload until granted.
    for (int n = 0; n < 10000; n++) begin
      if (!(m0Bus.req && !lastGnt[0])) applyStimulus(m0Bus.req, m0Bus.we, m0Bus.addr, m0Bus.wdata);
      if (!(m1Bus.req && !lastGnt[1])) applyStimulus(m1Bus.req, m1Bus.we, m1Bus.addr, m1Bus.wdata);
      runCycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
